// File: rtl/bcd_display_mux.sv
// Time-multiplexed 7-segment driver for a packed BCD word.
// Updates are double-buffered and committed only at frame boundaries, so a frame never tears.
module bcd_display_mux #(
  parameter int N_DIGITS      = 5,
  parameter int SCAN_DIV      = 50000,
  parameter bit BLANK_LEADING = 1'b1,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic                  bcd_valid,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done,
  output logic                  bcd_err
);

  localparam int PCNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [PCNT_W-1:0]   PCNT_MAX = PCNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_MAX  = IDX_W'(N_DIGITS - 1);
  localparam logic [6:0]          SEG_OFF  = {7{ACTIVE_LOW}};
  localparam logic [N_DIGITS-1:0] AN_OFF   = {N_DIGITS{ACTIVE_LOW}};

  logic [PCNT_W-1:0]     pcnt_q, pcnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pend_q, pend_d;
  logic [4*N_DIGITS-1:0] pend_reg_q, pend_reg_d;
  logic [4*N_DIGITS-1:0] disp_reg_q, disp_reg_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic                  frame_done_q, frame_done_d;
  logic                  bcd_err_q, bcd_err_d;

  logic                  tick;
  logic                  boundary;
  logic                  zero_run;
  logic [N_DIGITS-1:0]   lead_zero;
  logic [N_DIGITS-1:0]   an_sel;
  logic [3:0]            cur_nib;
  logic                  cur_blank;
  logic [6:0]            seg_raw;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  always_comb begin
    tick     = (pcnt_q == PCNT_MAX);
    boundary = tick && (idx_q == IDX_MAX);

    pcnt_d = tick ? '0 : pcnt_q + 1'b1;
    idx_d  = idx_q;
    if (tick) begin
      idx_d = boundary ? '0 : idx_q + 1'b1;
    end

    // A strobe on the boundary itself wins over anything still pending.
    pend_d     = pend_q;
    pend_reg_d = pend_reg_q;
    disp_reg_d = disp_reg_q;
    if (boundary) begin
      if (bcd_valid) begin
        disp_reg_d = bcd_in;
      end else if (pend_q) begin
        disp_reg_d = pend_reg_q;
      end
      pend_d = 1'b0;
    end else if (bcd_valid) begin
      pend_reg_d = bcd_in;
      pend_d     = 1'b1;
    end
  end

  // lead_zero[i] is set when nibbles N_DIGITS-1 down to i are all zero.
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_reg_q[4*i +: 4] == 4'd0);
      lead_zero[i] = zero_run;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    an_sel    = '0;
    bcd_err_d = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = disp_reg_q[4*i +: 4];
        cur_blank = BLANK_LEADING && (i != 0) && lead_zero[i];
        an_sel[i] = 1'b1;
      end
      if (disp_reg_q[4*i +: 4] > 4'd9) begin
        bcd_err_d = 1'b1;
      end
    end
    seg_raw      = cur_blank ? 7'h00 : seg_decode(cur_nib);
    seg_d        = ACTIVE_LOW ? ~seg_raw : seg_raw;
    an_d         = ACTIVE_LOW ? ~an_sel : an_sel;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q       <= '0;
      idx_q        <= '0;
      pend_q       <= 1'b0;
      pend_reg_q   <= '0;
      disp_reg_q   <= '0;
      seg_q        <= SEG_OFF;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
      bcd_err_q    <= 1'b0;
    end else begin
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      pend_q       <= pend_d;
      pend_reg_q   <= pend_reg_d;
      disp_reg_q   <= disp_reg_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      bcd_err_q    <= bcd_err_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;
  assign bcd_err    = bcd_err_q;

endmodule

// File: doc/bcd_display_mux.md
# bcd_display_mux

Multiplexed 7-segment display driver that consumes the 20-bit packed BCD word produced by the binary-to-BCD converter and shows it on a common-anode, time-multiplexed digit bank. It takes new values from a load strobe, commits them only at frame boundaries so digits never tear, and blanks leading zeros. Invalid nibbles are flagged. It is the last stage between the matrix-multiplication result path and the board display pins.

## Interface
- `N_DIGITS`, 5: number of digits. `bcd_in` width is `4*N_DIGITS`.
- `SCAN_DIV`, 50000: clock cycles each digit stays lit. Must be ≥1.
- `BLANK_LEADING`, 1: when 1, leading zero digits are dark.
- `ACTIVE_LOW`, 1: when 1, `seg` and `an` are inverted to drive active-low pins.

Ports:
- `clk` input 1: single clock; all state on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `bcd_in` input `4*N_DIGITS`: packed BCD. Nibble 0 (`[3:0]`) is the least significant digit.
- `bcd_valid` input 1: load strobe; `bcd_in` is sampled on each cycle this is high.
- `seg` output 7: segments `{g,f,e,d,c,b,a}`.
- `an` output `N_DIGITS`: digit enables; bit i drives digit i.
- `frame_done` output 1: one-cycle pulse when the scan wraps from digit `N_DIGITS-1` to digit 0.
- `bcd_err` output 1: high while any committed nibble is greater than 9.

## Operation
- Prescaler `pcnt` counts 0..`SCAN_DIV-1`, then wraps to 0.
  - `tick` = (`pcnt==SCAN_DIV-1`).
  - With `SCAN_DIV=1`, `tick` is high every cycle.
- Digit index `idx` counts 0..`N_DIGITS-1` and advances on `tick`. The boundary is `tick && idx==N_DIGITS-1`; at the boundary `idx` wraps to 0 and `frame_done` pulses.
- Double buffering:
  - When `bcd_valid` is high and it is not a boundary cycle: `pend_reg <= bcd_in` and `pend <= 1`. A later strobe overwrites the earlier one; last write wins.
  - On a boundary cycle with `pend=1` and `bcd_valid=0`: `disp_reg <= pend_reg` and `pend <= 0`.
  - On a boundary cycle with `bcd_valid=1`: `disp_reg <= bcd_in` directly, `pend <= 0`, and any older pending value is discarded.
- Blanking:
  - Digit i is blank when all of these hold: `BLANK_LEADING=1`, i≠0, and nibbles `N_DIGITS-1`..i of `disp_reg` are all zero.
  - Digit 0 is never blanked.
  - A blank digit drives all segments off, but its `an` bit still follows the scan.
- Segment decode (active-high values, before `ACTIVE_LOW` inversion):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibbles 10–15 display '-' = 40.
- `an`: exactly one bit active (digit `idx`); all others inactive.
- `bcd_err` is registered from `disp_reg`: it is high if any nibble of `disp_reg` is greater than 9.

## Timing
- Reset (asynchronous, while `rst_n`=0):
  - `pcnt`, `idx`, `pend`, `pend_reg`, `disp_reg` are 0.
  - `an` all inactive (all 1s when `ACTIVE_LOW`).
  - `seg` all off.
  - `frame_done` is 0 and `bcd_err` is 0.
- First cycle after reset release: outputs show digit 0 = '0'. All other digits are blank (when `BLANK_LEADING=1`).
- `an`, `seg`, `frame_done` and `bcd_err` are registered. They lag the `idx`/`disp_reg` state by one clock.
- A digit stays lit for exactly `SCAN_DIV` cycles. A full frame is `N_DIGITS*SCAN_DIV` cycles.
- Strobe-to-display latency:
  - The strobe value commits at the next boundary edge.
  - Digit 0 shows it one clock later.
  - Worst case is `N_DIGITS*SCAN_DIV+1` cycles.
- A mid-frame `bcd_valid` never changes the digits displayed in the current frame.
- Reset asserted mid-frame: all outputs go to their reset values immediately (asynchronous). Any pending update is lost.

## Test plan
- Reset values:
  - Hold `rst_n`=0 → `an`=5'b11111, `seg`=7'h7F, `frame_done`=0, `bcd_err`=0.
  - Release `rst_n` → digit 0 shows 0 (`seg`=~3F=7'h40), with `an`=5'b11110.
- Full scan, `SCAN_DIV`=4:
  - Strobe 20'h12345, wait one frame.
  - Required sequence: `an` walks 11110→11101→11011→10111→01111, 4 cycles each.
  - Segments show 5,4,3,2,1.
  - `frame_done` pulses once every 20 cycles.
- Leading-zero blanking: strobe 20'h00042 → digits 0,1 show 2,4; digits 2–4 have `seg` all off while their `an` is active.
  - With 20'h00000, only digit 0 shows '0'.
- Invalid nibble: strobe 20'h0001A → digit 0 shows '-' (active-high 40), digit 1 shows 1, and `bcd_err`=1 from the cycle after commit.
  - A later strobe of 20'h00001 clears `bcd_err` at the next commit.
- Deferred and last-wins update:
  - Strobe 20'h11111 while `idx`=2, then 20'h22222 while `idx`=3.
  - The current frame is unchanged, and the next frame shows 22222.
  - A strobe of 20'h33333 on the boundary cycle itself commits 33333 directly, overriding any pending value.
- Reset mid-frame with an update pending: assert `rst_n`=0 → outputs return to reset values within the same cycle. After release, the display shows '0', not the pending value.
